// File: rtl/bus_cycle_gen.sv
// bus_cycle_gen
//   Turns a single-cycle transfer request from the core into an 8085-style
//   multiplexed-bus machine cycle: T1 (address on AD, ale high), T2, optional
//   TW wait states while ready is low, T3, then back to idle with a done pulse.
//   A run of WAITMAX consecutive wait edges with ready low aborts the cycle and
//   pulses err instead. Every output is a register.
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   req, req_wr, req_io    request strobe, write/read select, io/memory select
//   req_addr, req_wdata    transfer address and write data (captured with req)
//   busy, done, err        cycle in progress, completion pulse, abort pulse
//   rdata                  last completed read data
//   ready                  external wait control (low inserts TW)
//   ale, io_m, rd_n, wr_n  bus control pins
//   a_hi                   high address byte, held for the whole cycle
//   ad_out, ad_oe, ad_in   multiplexed AD bus drive value, enable, sampled value

module bus_cycle_gen #(
    parameter int WAITMAX = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        req_wr,
    input  logic        req_io,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [7:0]  rdata,
    input  logic        ready,
    output logic        ale,
    output logic        io_m,
    output logic        rd_n,
    output logic        wr_n,
    output logic [7:0]  a_hi,
    output logic [7:0]  ad_out,
    output logic        ad_oe,
    input  logic [7:0]  ad_in
);

    localparam logic [7:0] WMAX = 8'(WAITMAX);

    typedef enum logic [2:0] {S_IDLE, S_T1, S_T2, S_TW, S_T3} state_t;

    state_t     state, state_nx;
    logic       wr_q, wr_nx;
    logic [7:0] wdata_q, wdata_nx;
    logic [7:0] wcnt, wcnt_nx;
    logic [7:0] wcnt_inc;

    logic       busy_nx, done_nx, err_nx, ale_nx, io_m_nx, rd_n_nx, wr_n_nx, ad_oe_nx;
    logic [7:0] rdata_nx, a_hi_nx, ad_out_nx;

    assign wcnt_inc = wcnt + 8'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            wr_q    <= 1'b0;
            wdata_q <= 8'h00;
            wcnt    <= 8'h00;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            rdata   <= 8'h00;
            ale     <= 1'b0;
            io_m    <= 1'b0;
            rd_n    <= 1'b1;
            wr_n    <= 1'b1;
            a_hi    <= 8'h00;
            ad_out  <= 8'h00;
            ad_oe   <= 1'b0;
        end else begin
            state   <= state_nx;
            wr_q    <= wr_nx;
            wdata_q <= wdata_nx;
            wcnt    <= wcnt_nx;
            busy    <= busy_nx;
            done    <= done_nx;
            err     <= err_nx;
            rdata   <= rdata_nx;
            ale     <= ale_nx;
            io_m    <= io_m_nx;
            rd_n    <= rd_n_nx;
            wr_n    <= wr_n_nx;
            a_hi    <= a_hi_nx;
            ad_out  <= ad_out_nx;
            ad_oe   <= ad_oe_nx;
        end
    end

    // Next-state logic also computes the next value of every output, so the
    // registered outputs line up with the state they describe.
    always_comb begin
        state_nx  = state;
        wr_nx     = wr_q;
        wdata_nx  = wdata_q;
        wcnt_nx   = wcnt;
        busy_nx   = busy;
        done_nx   = 1'b0;
        err_nx    = 1'b0;
        rdata_nx  = rdata;
        ale_nx    = ale;
        io_m_nx   = io_m;
        rd_n_nx   = rd_n;
        wr_n_nx   = wr_n;
        a_hi_nx   = a_hi;
        ad_out_nx = ad_out;
        ad_oe_nx  = ad_oe;

        case (state)
            S_IDLE: begin
                if (req) begin
                    state_nx  = S_T1;
                    wr_nx     = req_wr;
                    wdata_nx  = req_wdata;
                    busy_nx   = 1'b1;
                    ale_nx    = 1'b1;
                    io_m_nx   = req_io;
                    a_hi_nx   = req_addr[15:8];
                    ad_out_nx = req_addr[7:0];
                    ad_oe_nx  = 1'b1;
                end
            end
            S_T1: begin
                // Bus turnaround happens here: reads release AD as the strobe
                // falls, writes swap the address for the write data.
                state_nx = S_T2;
                ale_nx   = 1'b0;
                if (wr_q) begin
                    wr_n_nx   = 1'b0;
                    ad_out_nx = wdata_q;
                    ad_oe_nx  = 1'b1;
                end else begin
                    rd_n_nx  = 1'b0;
                    ad_oe_nx = 1'b0;
                end
            end
            S_T2: begin
                if (ready) begin
                    state_nx = S_T3;
                end else begin
                    state_nx = S_TW;
                    wcnt_nx  = 8'h00;
                end
            end
            S_TW: begin
                wcnt_nx = wcnt_inc;
                // ready takes priority over the abort on the final wait edge
                if (ready) begin
                    state_nx = S_T3;
                end else if (wcnt_inc == WMAX) begin
                    state_nx = S_IDLE;
                    err_nx   = 1'b1;
                    busy_nx  = 1'b0;
                    rd_n_nx  = 1'b1;
                    wr_n_nx  = 1'b1;
                    ad_oe_nx = 1'b0;
                end
            end
            S_T3: begin
                state_nx = S_IDLE;
                done_nx  = 1'b1;
                busy_nx  = 1'b0;
                rd_n_nx  = 1'b1;
                wr_n_nx  = 1'b1;
                ad_oe_nx = 1'b0;
                if (!wr_q) rdata_nx = ad_in;
            end
            default: state_nx = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_bus_cycle_gen.sv
module tb_bus_cycle_gen;

    localparam int W = 3;

    logic        clk = 1'b0;
    logic        rst, req, req_wr, req_io, ready;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata, ad_in;
    logic        busy, done, err, ale, io_m, rd_n, wr_n, ad_oe;
    logic [7:0]  rdata, a_hi, ad_out;

    bus_cycle_gen #(.WAITMAX(W)) dut (
        .clk(clk), .rst(rst), .req(req), .req_wr(req_wr), .req_io(req_io),
        .req_addr(req_addr), .req_wdata(req_wdata), .busy(busy), .done(done),
        .err(err), .rdata(rdata), .ready(ready), .ale(ale), .io_m(io_m),
        .rd_n(rd_n), .wr_n(wr_n), .a_hi(a_hi), .ad_out(ad_out), .ad_oe(ad_oe),
        .ad_in(ad_in)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic        io;
        logic [15:0] addr;
        logic [7:0]  wdata;
        int          busy_len;
        bit          is_err;
        logic [7:0]  rdata;
        int          gap;
    } exp_t;

    exp_t       q[$];
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         last_end = -1;
    int         bcnt = 0;
    bit         mon_en = 1'b0;
    logic [7:0] model_rdata = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        failures++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Monitor: samples on the falling edge and checks the bus against the
    // transaction at the head of the scoreboard queue.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (mon_en && !rst) begin
            if (ale) begin
                chk("ale_vs_strobe", {30'd0, rd_n, wr_n}, 32'd3);
                if (q.size() == 0) begin
                    flag("unexpected_t1");
                end else begin
                    e = q[0];
                    if (last_end >= 0) chk("t1_gap", 32'(cyc), 32'(last_end + 1 + e.gap));
                    chk("t1_ad_out", {24'd0, ad_out}, {24'd0, e.addr[7:0]});
                    chk("t1_a_hi", {24'd0, a_hi}, {24'd0, e.addr[15:8]});
                    chk("t1_io_m", {31'd0, io_m}, {31'd0, e.io});
                    chk("t1_ad_oe_busy", {30'd0, ad_oe, busy}, 32'd3);
                    bcnt = 1;
                end
            end else if (busy) begin
                bcnt++;
                if (q.size() != 0) begin
                    e = q[0];
                    chk("hold_a_hi", {24'd0, a_hi}, {24'd0, e.addr[15:8]});
                    chk("hold_io_m", {31'd0, io_m}, {31'd0, e.io});
                    if (e.wr) begin
                        chk("wr_strobes", {29'd0, rd_n, wr_n, ad_oe}, 32'b101);
                        chk("wr_data", {24'd0, ad_out}, {24'd0, e.wdata});
                    end else begin
                        chk("rd_strobes", {29'd0, rd_n, wr_n, ad_oe}, 32'b010);
                    end
                end
            end else begin
                chk("idle_pins", {28'd0, ale, rd_n, wr_n, ad_oe}, 32'b0110);
                if (done || err) begin
                    if (q.size() == 0) begin
                        flag("unexpected_end_pulse");
                    end else begin
                        e = q.pop_front();
                        chk("end_kind", {30'd0, done, err}, e.is_err ? 32'b01 : 32'b10);
                        chk("busy_len", 32'(bcnt), 32'(e.busy_len));
                        chk("rdata", {24'd0, rdata}, {24'd0, e.rdata});
                        last_end = cyc;
                    end
                end
            end
        end
    end

    // Issue one transfer. n = number of sampling edges with ready low starting
    // at the edge that ends T2; g = idle cycles before the request.
    task automatic run_tr(input logic wr, input logic io, input logic [15:0] addr,
                          input logic [7:0] wdata, input logic [7:0] rval,
                          input int n, input int g);
        exp_t e;
        bit   to;
        int   last;
        to = (n > W);
        repeat (g) begin
            req = 1'b0;
            ready = 1'($urandom);
            ad_in = 8'($urandom);
            tick();
        end
        req = 1'b1; req_wr = wr; req_io = io; req_addr = addr; req_wdata = wdata;
        ready = 1'($urandom);
        ad_in = 8'($urandom);
        if (!to && !wr) model_rdata = rval;
        e.wr = wr; e.io = io; e.addr = addr; e.wdata = wdata;
        e.busy_len = to ? W + 2 : n + 3;
        e.is_err = to;
        e.rdata = model_rdata;
        e.gap = g;
        q.push_back(e);
        tick();  // E0
        last = to ? 2 + W : 3 + n;
        for (int k = 1; k <= last; k++) begin
            // request held high with junk fields while busy; must be ignored
            req = 1'b1;
            req_wr = 1'($urandom); req_io = 1'($urandom);
            req_addr = 16'($urandom); req_wdata = 8'($urandom);
            ready = (k < 2) ? 1'($urandom) : ((k - 2) < n ? 1'b0 : 1'b1);
            ad_in = (k == last && !to) ? rval : 8'($urandom);
            tick();
        end
    endtask

    task automatic drain;
        int k = 0;
        req = 1'b0;
        while (q.size() != 0 && k < 200) begin
            tick();
            k++;
        end
        if (q.size() != 0) flag("drain_timeout");
        tick();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy_done_err"}, {29'd0, busy, done, err}, 32'd0);
        chk({tag, "_rdata"}, {24'd0, rdata}, 32'd0);
        chk({tag, "_ale_io_m"}, {30'd0, ale, io_m}, 32'd0);
        chk({tag, "_strobes_oe"}, {29'd0, rd_n, wr_n, ad_oe}, 32'b110);
        chk({tag, "_a_hi"}, {24'd0, a_hi}, 32'd0);
        chk({tag, "_ad_out"}, {24'd0, ad_out}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; req_wr = 1'b0; req_io = 1'b0; ready = 1'b1;
        req_addr = 16'h0; req_wdata = 8'h0; ad_in = 8'h0;
        tick(); tick();
        @(negedge clk);
        chk_reset_vals("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        mon_en = 1'b1;

        // directed cases
        run_tr(1'b0, 1'b0, 16'h12A5, 8'h00, 8'h3C, 0, 0);
        run_tr(1'b1, 1'b1, 16'h00F0, 8'h5A, 8'h00, 2, 1);
        run_tr(1'b0, 1'b0, 16'h4321, 8'h00, 8'hEE, W + 1, 1);   // timeout
        run_tr(1'b0, 1'b0, 16'h1111, 8'h00, 8'h99, W, 1);       // ready on last wait edge
        run_tr(1'b0, 1'b0, 16'hAAAA, 8'h00, 8'hC3, 0, 1);
        run_tr(1'b1, 1'b0, 16'h5555, 8'h66, 8'h00, 0, 0);       // back-to-back

        // randomized transfers
        for (int i = 0; i < 40; i++) begin
            run_tr(1'($urandom), 1'($urandom), 16'($urandom), 8'($urandom),
                   8'($urandom), int'($urandom_range(0, W + 1)),
                   int'($urandom_range(0, 2)));
        end
        drain();

        // reset in the middle of a write's wait states
        mon_en = 1'b0;
        req = 1'b1; req_wr = 1'b1; req_io = 1'b1; req_addr = 16'hBEEF; req_wdata = 8'h77;
        ready = 1'b0;
        tick();              // E0 -> T1
        req = 1'b0;
        tick();              // E1 -> T2
        tick();              // E2 -> TW
        tick();              // E3 -> TW
        chk("tw_wr_n", {31'd0, wr_n}, 32'd0);
        rst = 1'b1;
        tick();
        @(negedge clk);
        chk_reset_vals("midreset");
        @(posedge clk); #1;
        rst = 1'b0;
        ready = 1'b1;
        model_rdata = 8'h00;
        last_end = -1;
        mon_en = 1'b1;
        run_tr(1'b0, 1'b0, 16'h2468, 8'h00, 8'hA7, 1, 1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bus_cycle_gen.md
# bus_cycle_gen

Bus-cycle generator for the 8085-style multiplexed address/data bus. It turns a single-cycle transfer request from the core into a T1/T2/(TW)/T3 machine cycle. During T1 it drives the low address on AD with ALE high, so the external address latch captures it. During T2/T3 it drives RD_/WR_ and data. It sits between the core's execution unit and the pin-level bus.

## Interface
Parameters:
- WAITMAX, 15: maximum consecutive TW cycles before the cycle is aborted; range 1..255.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  1  transfer request; sampled only while busy=0.
- req_wr  input  1  1 = write cycle, 0 = read cycle; sampled with req.
- req_io  input  1  1 = I/O cycle, 0 = memory cycle; sampled with req.
- req_addr  input  16  transfer address; sampled with req.
- req_wdata  input  8  write data; sampled with req.
- busy  output  1  high from T1 through T3.
- done  output  1  one-cycle pulse after a completed cycle.
- err  output  1  one-cycle pulse after a WAITMAX abort.
- rdata  output  8  read data; updated only on a completed read.
- ready  input  1  external wait control; low inserts TW states.
- ale  output  1  address latch enable; high only in T1.
- io_m  output  1  copy of the captured req_io for the whole cycle.
- rd_n  output  1  active-low read strobe.
- wr_n  output  1  active-low write strobe.
- a_hi  output  8  captured address[15:8], held for the whole cycle.
- ad_out  output  8  AD bus drive value.
- ad_oe  output  1  AD bus drive enable.
- ad_in  input  8  AD bus sampled value.

## Operation
- States: IDLE, T1, T2, TW, T3. All outputs are registered.
- IDLE:
  - busy=0, ale=0, rd_n=wr_n=1, ad_oe=0.
  - req=1 captures req_wr, req_io, req_addr and req_wdata, then moves to T1.
- T1:
  - ale=1, ad_out=addr[7:0], ad_oe=1, a_hi=addr[15:8], io_m=req_io.
  - Always moves to T2.
- T2:
  - ale=0.
  - Read: rd_n=0, ad_oe=0.
  - Write: wr_n=0, ad_out=wdata, ad_oe=1.
  - At the edge ending T2: ready=1 moves to T3; ready=0 moves to TW and clears the wait counter.
- TW:
  - Outputs are held as in T2.
  - Each edge increments the wait counter.
  - ready=1 moves to T3.
  - If the counter reaches WAITMAX with ready=0, move to IDLE with err pulsed. Strobes deassert and rdata is unchanged.
  - If ready=1 on the WAITMAX-th edge, ready wins and the state moves to T3.
- T3:
  - Strobes and ad_out are held.
  - At the edge ending T3: a read captures ad_in into rdata. State moves to IDLE with done=1 for one cycle, and rd_n, wr_n and ad_oe are released.
- a_hi and io_m hold their last values in IDLE. ad_out also holds its last value but is not driven (ad_oe=0).
- req while busy=1 is ignored; there is no queueing.
- In the done/err cycle the state is already IDLE, so a req held high is accepted and T1 begins on the next cycle. Back-to-back cycles are 4 clocks apart with ready=1.
- rst=1 at any edge forces IDLE and reset values on the following cycle, regardless of state. No done or err pulse is generated for the aborted cycle.
- Reset values: busy=0, done=0, err=0, rdata=0, ale=0, io_m=0, rd_n=1, wr_n=1, a_hi=0, ad_out=0, ad_oe=0.

## Timing
- Edges are numbered from E0, the edge that samples req=1 in IDLE.
  - After E0: T1 (ale=1, busy=1).
  - After E1: T2 (strobe low).
  - After E2 with ready=1: T3.
  - After E3: IDLE with done=1.
  - Total: 3 clocks of busy, with done in the 4th.
- Each TW adds exactly one clock. With N waits, done is high in cycle N+4.
- ale is high for exactly one clock per cycle and never overlaps rd_n=0 or wr_n=0.
- ad_oe is 0 for at least the full T2..T3 span on reads. The bus turnaround from address to input happens at the T1→T2 edge.
- rdata samples ad_in at the T3→IDLE edge only.
- With WAITMAX=W and ready held low, err is high in cycle W+3 and busy spans W+2 cycles.

## Test plan
- Memory read, ready=1: req addr=16'h12A5, req_wr=0, ad_in=8'h3C in T3.
  - T1: ale=1, ad_out=8'hA5, a_hi=8'h12.
  - T2/T3: rd_n=0, ad_oe=0.
  - done in cycle 4 with rdata=8'h3C.
- I/O write with two waits: req addr=16'h00F0, wdata=8'h5A, req_io=1, ready low for the first two sampling edges.
  - Cycle: T1, T2, TW, TW, T3.
  - wr_n=0 and ad_out=8'h5A from T2 through T3; io_m=1 throughout.
  - done in cycle 6.
- Timeout: WAITMAX=3, read with ready stuck low.
  - 3 TW cycles, then err=1 in cycle 6.
  - done=0; rdata is unchanged from the previous value.
  - rd_n returns to 1.
- Back-to-back: req held high across two transfers, read 16'hAAAA then write 16'h5555.
  - The second T1 (ale=1, ad_out=8'h55) falls in the cycle after the first done.
  - The request presented while busy=1 is not accepted.
- Reset mid-cycle: assert rst during TW of a write.
  - Next cycle: wr_n=1, ad_oe=0, busy=0, all outputs at reset values, no done.
  - A new req after release completes normally.
- Strobe separation: over all of the above, check that ale=1 never coincides with rd_n=0 or wr_n=0.
